// File: rtl/amp_cfg_sequencer.sv
// Boot/config sequencer: snapshots bootmem on a config_trig rising edge and plays
// up to four (register, value) pairs into the shared I2C write master with retry.
module amp_cfg_sequencer #(
  parameter logic [6:0]  DEV_ADDR  = 7'h2C,
  parameter logic [7:0]  END_MARK  = 8'hFF,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        config_trig,
  input  logic [63:0] bootmem,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [6:0]  wr_dev_addr,
  output logic [7:0]  wr_reg,
  output logic [7:0]  wr_data,
  input  logic        wr_done,
  input  logic        wr_nack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_index,
  output logic [2:0]  pairs_sent
);

  localparam int unsigned RW = (MAX_RETRY < 4) ? 2 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [15:0]   TO_LIMIT  = 16'(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          trig_q;
  logic [63:0]   shadow_q, shadow_d;
  logic [2:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [1:0]    erri_q, erri_d;
  logic [2:0]    sent_q, sent_d;

  logic          start;
  logic [7:0]    cur_reg;
  logic [7:0]    cur_data;
  logic [15:0]   cnt_next;

  assign start    = config_trig & ~trig_q;
  assign cur_reg  = shadow_q[{idx_q[1:0], 4'd0} +: 8];
  assign cur_data = shadow_q[{idx_q[1:0], 4'd8} +: 8];
  assign cnt_next = (cnt_q == TO_LIMIT) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    error_d  = error_q;
    erri_d   = erri_q;
    sent_d   = sent_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d = bootmem;
          done_d   = 1'b0;
          error_d  = 1'b0;
          erri_d   = '0;
          sent_d   = '0;
          idx_d    = '0;
          retry_d  = '0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        // done is raised on entry so it is already visible during the DONE cycle
        if (idx_q == 3'd4 || cur_reg == END_MARK) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (wr_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_next;
        // an ack wins over a timeout landing on the same cycle
        if (wr_done && !wr_nack) begin
          sent_d  = sent_q + 3'd1;
          idx_d   = idx_q + 3'd1;
          retry_d = '0;
          state_d = S_CHECK;
        end else if ((wr_done && wr_nack) || cnt_next == TO_LIMIT) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_REQ;
          end else begin
            error_d = 1'b1;
            erri_d  = idx_q[1:0];
            state_d = S_ERROR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_REQ);
    busy_d  = (state_d == S_CHECK) || (state_d == S_REQ) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      trig_q   <= 1'b0;
      shadow_q <= '0;
      idx_q    <= '0;
      retry_q  <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      erri_q   <= '0;
      sent_q   <= '0;
    end else begin
      state_q  <= state_d;
      trig_q   <= config_trig;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      erri_q   <= erri_d;
      sent_q   <= sent_d;
    end
  end

  // payload is forced to zero outside a request so idle outputs read as all-zero
  assign wr_valid    = valid_q;
  assign wr_dev_addr = valid_q ? DEV_ADDR : '0;
  assign wr_reg      = valid_q ? cur_reg  : '0;
  assign wr_data     = valid_q ? cur_data : '0;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_index   = erri_q;
  assign pairs_sent  = sent_q;

endmodule

// File: tb/tb_amp_cfg_sequencer.sv
// Randomized bench for amp_cfg_sequencer: transaction-level reference model with
// per-cycle output comparison, plus literal checks of the directed scenarios.
module tb_amp_cfg_sequencer;
  localparam int TO   = 24;
  localparam int MAXR = 3;

  localparam int P_IDLE = 0, P_CHECK = 1, P_REQ = 2, P_WAIT = 3, P_DONE = 4, P_ERR = 5;

  logic        clk = 1'b0;
  logic        rst, config_trig, wr_ready, wr_done, wr_nack;
  logic [63:0] bootmem;
  logic        wr_valid, busy, done, error;
  logic [6:0]  wr_dev_addr;
  logic [7:0]  wr_reg, wr_data;
  logic [1:0]  err_index;
  logic [2:0]  pairs_sent;

  always #5 clk = ~clk;

  amp_cfg_sequencer #(
    .DEV_ADDR(7'h2C), .END_MARK(8'hFF), .MAX_RETRY(MAXR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .config_trig(config_trig), .bootmem(bootmem),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dev_addr(wr_dev_addr),
    .wr_reg(wr_reg), .wr_data(wr_data), .wr_done(wr_done), .wr_nack(wr_nack),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .pairs_sent(pairs_sent)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // reference model: pending pairs of the running sequence in issue order
  int          m_phase = P_IDLE;
  logic [15:0] m_pend[$];
  int          m_att, m_wcnt, m_sent, m_erri;
  bit          m_busy, m_done, m_err, m_prev_trig, m_accepted;
  int          start_cyc, done_cyc;
  bit          done_prev;

  logic [7:0]  log_reg[$], log_data[$];
  logic [6:0]  log_dev[$];
  int          log_cyc[$];

  always @(posedge clk) begin
    bit start;
    logic [7:0] r;
    cyc++;
    if (wr_valid && wr_ready && !rst) begin
      log_reg.push_back(wr_reg);
      log_data.push_back(wr_data);
      log_dev.push_back(wr_dev_addr);
      log_cyc.push_back(cyc);
    end
    m_accepted = 0;
    if (rst) begin
      m_phase = P_IDLE; m_pend.delete(); m_att = 0; m_wcnt = 0; m_sent = 0; m_erri = 0;
      m_busy = 0; m_done = 0; m_err = 0; m_prev_trig = 0;
    end else begin
      start = config_trig && !m_prev_trig;
      m_prev_trig = config_trig;
      case (m_phase)
        P_IDLE: if (start) begin
          m_pend.delete();
          for (int k = 0; k < 4; k++) begin
            r = bootmem[16*k +: 8];
            if (r == 8'hFF) break;
            m_pend.push_back(bootmem[16*k +: 16]);
          end
          m_done = 0; m_err = 0; m_erri = 0; m_sent = 0; m_att = 0;
          m_busy = 1; m_phase = P_CHECK; start_cyc = cyc - 1;
        end
        P_CHECK: if (m_pend.size() == 0) begin
          m_phase = P_DONE; m_done = 1; m_busy = 0;
        end else m_phase = P_REQ;
        P_REQ: if (wr_ready) begin
          m_phase = P_WAIT; m_wcnt = 0; m_accepted = 1;
        end
        P_WAIT: begin
          m_wcnt++;
          if (wr_done && !wr_nack) begin
            void'(m_pend.pop_front());
            m_sent++; m_att = 0; m_phase = P_CHECK;
          end else if ((wr_done && wr_nack) || m_wcnt == TO) begin
            if (m_att < MAXR) begin
              m_att++; m_phase = P_REQ;
            end else begin
              m_phase = P_ERR; m_err = 1; m_erri = m_sent; m_busy = 0;
            end
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
    #1;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("pairs_sent", pairs_sent, m_sent);
    chk("wr_valid", wr_valid, m_phase == P_REQ);
    if (m_err) chk("err_index", err_index, m_erri);
    if (m_phase == P_REQ) begin
      chk("wr_reg", wr_reg, m_pend[0][7:0]);
      chk("wr_data", wr_data, m_pend[0][15:8]);
      chk("wr_dev_addr", wr_dev_addr, 7'h2C);
    end
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
  end

  // slave / I2C-master responder
  int cfg_ready_delay = 0, cfg_lat_max = 0, cfg_nack_pair = -1, cfg_nack_times = 0;
  int cfg_silent_pair = -1, cfg_nack_pct = 0;
  bit cfg_spurious = 0;
  int rs_pair = -1, rs_att = 0, rs_lat = 0, rs_delay = 0;
  bit rs_pending = 0, rs_prev_valid = 0;

  always @(negedge clk) begin
    wr_done = 1'b0;
    wr_nack = 1'($urandom_range(0, 1));
    if (rst) begin
      rs_pending = 0; rs_pair = -1; wr_ready = 1'b0; rs_prev_valid = 0;
    end else begin
      if (m_phase == P_IDLE) rs_pair = -1;
      if (m_accepted) begin
        if (m_sent != rs_pair) begin rs_pair = m_sent; rs_att = 0; end
        else rs_att++;
        rs_pending = (rs_pair != cfg_silent_pair);
        rs_lat = $urandom_range(0, cfg_lat_max);
      end
      if (rs_pending) begin
        if (rs_lat == 0) begin
          wr_done = 1'b1;
          wr_nack = (rs_pair == cfg_nack_pair && rs_att < cfg_nack_times) ||
                    ($urandom_range(0, 99) < cfg_nack_pct);
          rs_pending = 0;
        end else rs_lat--;
      end else if (cfg_spurious && m_phase != P_WAIT && $urandom_range(0, 3) == 0) begin
        wr_done = 1'b1;
      end
      if (wr_valid) begin
        if (!rs_prev_valid)
          rs_delay = (cfg_ready_delay < 0) ? $urandom_range(0, 3) : cfg_ready_delay;
        if (rs_delay > 0) begin wr_ready = 1'b0; rs_delay--; end
        else wr_ready = 1'b1;
      end else wr_ready = 1'($urandom_range(0, 1));
      rs_prev_valid = wr_valid;
    end
  end

  task automatic pulse_trig(input logic [63:0] bm);
    @(negedge clk);
    bootmem = bm;
    config_trig = 1'b1;
    @(negedge clk);
    config_trig = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (m_phase == P_IDLE) break;
      @(negedge clk);
    end
    if (i == budget) fail(name);
  endtask

  task automatic chk_log(input string name, input int idx, input logic [7:0] rg, input logic [7:0] dt);
    if (idx >= log_reg.size()) fail(name);
    else begin
      chk({name, "_reg"}, log_reg[idx], rg);
      chk({name, "_data"}, log_data[idx], dt);
      chk({name, "_dev"}, log_dev[idx], 7'h2C);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] BM4 = {8'h44, 8'h04, 8'h33, 8'h03, 8'h22, 8'h02, 8'h11, 8'h01};

  initial begin
    int base;
    logic [63:0] bm;
    rst = 1'b1; config_trig = 1'b0; bootmem = '0;
    wr_ready = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", wr_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_sent", pairs_sent, 3'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // two pairs then end mark
    base = log_reg.size();
    pulse_trig({8'h00, 8'h00, 8'h00, 8'hFF, 8'h22, 8'h10, 8'h80, 8'h07});
    wait_idle("t1_seq", 200);
    chk("t1_count", log_reg.size() - base, 2);
    chk_log("t1_p0", base, 8'h07, 8'h80);
    chk_log("t1_p1", base + 1, 8'h10, 8'h22);
    chk("t1_sent", pairs_sent, 3'd2);
    chk("t1_done", done, 1'b1);
    chk("t1_error", error, 1'b0);

    // four pairs, slow ready
    cfg_ready_delay = 5;
    base = log_reg.size();
    pulse_trig(BM4);
    wait_idle("t2_seq", 400);
    chk("t2_count", log_reg.size() - base, 4);
    for (int k = 0; k < 4; k++)
      chk_log("t2_p", base + k, 8'(k + 1), 8'(17 * (k + 1)));
    chk("t2_sent", pairs_sent, 3'd4);
    chk("t2_done", done, 1'b1);

    // pair 1 NACKed twice
    cfg_ready_delay = 0; cfg_nack_pair = 1; cfg_nack_times = 2; cfg_lat_max = 2;
    base = log_reg.size();
    pulse_trig(BM4);
    wait_idle("t3_seq", 400);
    chk("t3_count", log_reg.size() - base, 6);
    chk_log("t3_a0", base, 8'h01, 8'h11);
    for (int k = 1; k < 4; k++) chk_log("t3_retry", base + k, 8'h02, 8'h22);
    chk_log("t3_a4", base + 4, 8'h03, 8'h33);
    chk("t3_sent", pairs_sent, 3'd4);
    chk("t3_done", done, 1'b1);
    chk("t3_error", error, 1'b0);
    cfg_nack_pair = -1; cfg_nack_times = 0;

    // pair 2 never answered
    cfg_silent_pair = 2; cfg_lat_max = 0;
    base = log_reg.size();
    pulse_trig(BM4);
    wait_idle("t4_seq", 4 * (TO + 4) + 100);
    chk("t4_count", log_reg.size() - base, 6);
    for (int k = 2; k < 6; k++) chk_log("t4_att", base + k, 8'h03, 8'h33);
    for (int k = 3; k < 6; k++)
      if (base + k < log_cyc.size())
        chk("t4_spacing", log_cyc[base + k] - log_cyc[base + k - 1], TO + 1);
    chk("t4_error", error, 1'b1);
    chk("t4_err_index", err_index, 2'd2);
    chk("t4_sent", pairs_sent, 3'd2);
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done, 1'b0);
    cfg_silent_pair = -1;

    // edge during busy and bootmem change are ignored
    cfg_ready_delay = 2; cfg_lat_max = 3;
    base = log_reg.size();
    pulse_trig(BM4);
    repeat (4) @(negedge clk);
    bootmem = ~BM4;
    config_trig = 1'b1;
    @(negedge clk);
    config_trig = 1'b0;
    wait_idle("t5_seq", 400);
    chk("t5_count", log_reg.size() - base, 4);
    for (int k = 0; k < 4; k++)
      chk_log("t5_p", base + k, 8'(k + 1), 8'(17 * (k + 1)));
    repeat (3) @(negedge clk);
    chk("t5_no_requeue", busy, 1'b0);

    // reset in WAIT, then restart
    cfg_silent_pair = 1;
    pulse_trig(BM4);
    for (int i = 0; i < 200 && !(m_phase == P_WAIT && m_sent == 1); i++) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_sent", pairs_sent, 3'd0);
    chk("t5_rst_valid", wr_valid, 1'b0);
    rst = 1'b0;
    cfg_silent_pair = -1;
    base = log_reg.size();
    pulse_trig(BM4);
    wait_idle("t5_restart", 400);
    chk_log("t5_restart_p0", base, 8'h01, 8'h11);
    chk("t5_restart_sent", pairs_sent, 3'd4);

    // end mark in pair 0
    base = log_reg.size();
    pulse_trig({48'h1234_5678_9ABC, 8'h5A, 8'hFF});
    wait_idle("t6_seq", 50);
    chk("t6_count", log_reg.size() - base, 0);
    chk("t6_done_latency", done_cyc - start_cyc, 2);
    chk("t6_sent", pairs_sent, 3'd0);
    chk("t6_done", done, 1'b1);

    // trigger held high through reset
    @(negedge clk);
    bootmem = BM4; config_trig = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = log_reg.size();
    @(negedge clk);
    wait_idle("t7_seq", 400);
    config_trig = 1'b0;
    chk("t7_count", log_reg.size() - base, 4);
    chk("t7_done", done, 1'b1);

    // randomized sequences
    cfg_ready_delay = -1; cfg_lat_max = 3; cfg_nack_pct = 15; cfg_spurious = 1;
    for (int s = 0; s < 25; s++) begin
      for (int k = 0; k < 4; k++) begin
        bm[16*k +: 8]     = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        bm[16*k + 8 +: 8] = 8'($urandom);
      end
      pulse_trig(bm);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) @(negedge clk);
        bootmem = 64'($urandom) ^ {32'($urandom), 32'd0};
      end
      wait_idle("rand_seq", 4 * 4 * (TO + 8) + 100);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
